// File: rtl/delay_ctrl_sequencer.sv
// Control/feed stage for the programmable delay line: it walks the tap select one step at a time and registers the sample stream.
// Define DELAY_CTRL_BLANK_EN to drive IDLE_PATTERN on data_out while a tap walk is in progress.
module delay_ctrl_sequencer #(
    parameter int                 DATA_W        = 8,
    parameter int                 DELAY_W       = 4,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [DELAY_W-1:0] RESET_DELAY   = '0,
    parameter logic [DATA_W-1:0]  IDLE_PATTERN  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [DELAY_W-1:0] req_delay,
    output logic               req_ready,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic [DELAY_W-1:0] delay_value,
    output logic [DATA_W-1:0]  data_out,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STEP   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    logic [1:0]         state;
    logic [DELAY_W-1:0] target;
    logic [CNT_W-1:0]   cnt;

    assign req_ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            target      <= RESET_DELAY;
            delay_value <= RESET_DELAY;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        target <= req_delay;
                        if (req_delay == delay_value) begin
                            done <= 1'b1;
                        end else begin
                            state <= S_STEP;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_STEP: begin
                    // Single-tap move only; a multi-tap jump would corrupt samples in flight.
                    if (target > delay_value)
                        delay_value <= delay_value + DELAY_W'(1);
                    else
                        delay_value <= delay_value - DELAY_W'(1);
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                    state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        if (delay_value == target) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= S_STEP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= IDLE_PATTERN;
`ifdef DELAY_CTRL_BLANK_EN
        end else if (busy) begin
            data_out <= IDLE_PATTERN;
`endif
        end else begin
            data_out <= in_valid ? in_data : IDLE_PATTERN;
        end
    end

endmodule
